// File: rtl/vpi_call_arbiter_if.sv
// ---------------------------------------------------------------------------
// vpi_call_arbiter_if : requester/sink bundle for the VPI call arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vpi_call_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*7-1:0]  req_b;
  logic [NUM_REQ*32-1:0] req_c;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           out_a;
  logic [6:0]            out_b;
  logic [31:0]           out_c;
  logic                  out_valid;
  logic                  out_ready;
  logic [GID_W-1:0]      grant_id;
  logic                  busy;
  logic [31:0]           call_count;

  modport master (
    output req_valid, req_a, req_b, req_c, out_ready,
    input  req_ready, out_a, out_b, out_c, out_valid, grant_id, busy, call_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, out_ready,
    output req_ready, out_a, out_b, out_c, out_valid, grant_id, busy, call_count
  );
endinterface

`default_nettype wire

// File: rtl/vpi_call_arbiter.sv
// ---------------------------------------------------------------------------
// vpi_call_arbiter : round-robin share of one VPI parameter-call sink
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpi_call_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GID_W       = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  vpi_call_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [7:0]       HOLD_INIT = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
  localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);

  state_t           state_q;
  logic [7:0]       hold_q;
  logic [GID_W-1:0] last_q;
  logic [GID_W-1:0] grant_q;
  logic [15:0]      a_q;
  logic [6:0]       b_q;
  logic [31:0]      c_q;
  logic             valid_q;
  logic [31:0]      count_q;

  logic [GID_W-1:0]   grant_d;
  logic               any_req_d;
  logic [15:0]        a_d;
  logic [6:0]         b_d;
  logic [31:0]        c_d;
  logic [NUM_REQ-1:0] ready_d;
  int                 dist_d;
  int                 best_d;

  // Pick the valid requester closest after last_q in wrap-around order.
  always_comb begin
    grant_d = '0;
    best_d  = NUM_REQ;
    dist_d  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_d = (i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
      if (bus.req_valid[i] && (dist_d < best_d)) begin
        best_d  = dist_d;
        grant_d = GID_W'(i);
      end
    end
    any_req_d = (best_d < NUM_REQ);

    a_d     = '0;
    b_d     = '0;
    c_d     = '0;
    ready_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d == GID_W'(i)) begin
        a_d        = bus.req_a[i*16 +: 16];
        b_d        = bus.req_b[i*7 +: 7];
        c_d        = bus.req_c[i*32 +: 32];
        ready_d[i] = (state_q == S_IDLE) && any_req_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      last_q  <= LAST_INIT;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            grant_q <= grant_d;
            if (HOLD_CYCLES == 0) begin
              state_q <= S_ISSUE;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_HOLD;
              hold_q  <= HOLD_INIT;
            end
          end
        end
        S_HOLD: begin
          if (hold_q == 8'd0) begin
            state_q <= S_ISSUE;
            valid_q <= 1'b1;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        S_ISSUE: begin
          // The granted requester only drops to lowest priority once the sink takes it.
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 32'd1;
            last_q  <= grant_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_d;
  assign bus.out_a      = a_q;
  assign bus.out_b      = b_q;
  assign bus.out_c      = c_q;
  assign bus.out_valid  = valid_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.call_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_vpi_call_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vpi_call_arbiter : directed bench for vpi_call_arbiter (HOLD 2 and HOLD 0)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vpi_call_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vpi_call_arbiter_if #(.NUM_REQ(4), .GID_W(2)) bus ();
  vpi_call_arbiter_if #(.NUM_REQ(4), .GID_W(2)) bus0 ();

  vpi_call_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(2), .GID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vpi_call_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(0), .GID_W(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  function automatic logic [15:0] ea(int i); return 16'hA000 + 16'(i); endfunction
  function automatic logic [6:0]  eb(int i); return 7'h10 + 7'(i); endfunction
  function automatic logic [31:0] ec(int i); return 32'hC0DE0000 + 32'(i * 17); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slices();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*16 +: 16]  = ea(i);
      bus.req_b[i*7 +: 7]    = eb(i);
      bus.req_c[i*32 +: 32]  = ec(i);
      bus0.req_a[i*16 +: 16] = ea(i);
      bus0.req_b[i*7 +: 7]   = eb(i);
      bus0.req_c[i*32 +: 32] = ec(i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.out_ready  = 1'b0;
    bus0.req_valid = '0;
    bus0.out_ready = 1'b0;
    load_slices();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_vec++; if (bus.call_count !== 32'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.call_count); end
    n_vec++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL reset_gid got=%0d exp=0", bus.grant_id); end
    n_vec++; if ({bus.out_a, bus.out_b, bus.out_c} !== 55'd0) begin n_err++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.out_a, bus.out_b, bus.out_c); end
    n_vec++; if ({bus0.out_valid, bus0.call_count} !== 33'd0) begin n_err++; $display("FAIL reset_dut0 got=%b/%0d exp=0/0", bus0.out_valid, bus0.call_count); end
  endtask

  task automatic test_single();
    bus.req_a[15:0] = 16'h1234;
    bus.req_b[6:0]  = 7'h55;
    bus.req_c[31:0] = 32'hDEADBEEF;
    bus.out_ready   = 1'b1;
    bus.req_valid   = 4'b0001;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_drop got=%b exp=0000", bus.req_ready); end
    n_vec++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_hold1 busy=%b valid=%b exp=1/0", bus.busy, bus.out_valid); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_hold2 got=%b exp=0", bus.out_valid); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    n_vec++; if (bus.out_a !== 16'h1234 || bus.out_b !== 7'h55 || bus.out_c !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_data got=%h/%h/%h exp=1234/55/deadbeef", bus.out_a, bus.out_b, bus.out_c); end
    n_vec++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL single_gid got=%0d exp=0", bus.grant_id); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_done valid=%b busy=%b exp=0/0", bus.out_valid, bus.busy); end
    n_vec++; if (bus.call_count !== 32'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", bus.call_count); end
    load_slices();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    int g;
    do_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_rdy = 4'(1 << g);
      #1;
      n_vec++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      tick();
      n_vec++; if (bus.grant_id !== 2'(g)) begin n_err++; $display("FAIL fair_gid[%0d] got=%0d exp=%0d", k, bus.grant_id, g); end
      tick();
      tick();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_a !== ea(g) || bus.out_b !== eb(g) || bus.out_c !== ec(g)) begin
        n_err++; $display("FAIL fair_data[%0d] valid=%b got=%h/%h/%h exp=%h/%h/%h", k, bus.out_valid,
                          bus.out_a, bus.out_b, bus.out_c, ea(g), eb(g), ec(g)); end
      tick();
    end
    bus.req_valid = 4'b0000;
    #1;
    n_vec++; if (bus.call_count !== 32'd5) begin n_err++; $display("FAIL fair_count got=%0d exp=5", bus.call_count); end
  endtask

  task automatic test_rotation();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b1001;
    #1;
    n_vec++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rot_ready got=%b exp=1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    n_vec++; if (bus.grant_id !== 2'd3 || bus.out_a !== ea(3)) begin n_err++; $display("FAIL rot_gid got=%0d/%h exp=3/%h", bus.grant_id, bus.out_a, ea(3)); end
    tick();
    tick();
    tick();
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rot_next got=%b exp=0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    #1;
    n_vec++; if (bus.call_count !== 32'd7) begin n_err++; $display("FAIL rot_count got=%0d exp=7", bus.call_count); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    bus.req_valid = 4'b1011;
    #1;
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== ea(2) || bus.out_b !== eb(2) || bus.out_c !== ec(2) ||
          bus.call_count !== 32'd7 || bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd2) begin
        n_err++; $display("FAIL stall[%0d] valid=%b data=%h/%h/%h cnt=%0d rdy=%b gid=%0d exp=1 %h/%h/%h 7 0000 2", k,
                          bus.out_valid, bus.out_a, bus.out_b, bus.out_c, bus.call_count, bus.req_ready, bus.grant_id,
                          ea(2), eb(2), ec(2));
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_vec++; if (bus.call_count !== 32'd8 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release cnt=%0d valid=%b exp=8/0", bus.call_count, bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.call_count !== 32'd8) begin n_err++; $display("FAIL bp_once got=%0d exp=8", bus.call_count); end
  endtask

  task automatic test_hold0();
    do_reset();
    bus0.out_ready = 1'b1;
    bus0.req_valid = 4'b0011;
    #1;
    n_vec++; if (bus0.req_ready !== 4'b0001) begin n_err++; $display("FAIL h0_ready0 got=%b exp=0001", bus0.req_ready); end
    tick();
    n_vec++; if (bus0.out_valid !== 1'b1 || bus0.grant_id !== 2'd0 || bus0.out_a !== ea(0) || bus0.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL h0_issue0 valid=%b gid=%0d a=%h rdy=%b exp=1/0/%h/0000", bus0.out_valid, bus0.grant_id, bus0.out_a, bus0.req_ready, ea(0)); end
    tick();
    n_vec++; if (bus0.call_count !== 32'd1 || bus0.req_ready !== 4'b0010) begin
      n_err++; $display("FAIL h0_idle1 cnt=%0d rdy=%b exp=1/0010", bus0.call_count, bus0.req_ready); end
    tick();
    n_vec++; if (bus0.out_valid !== 1'b1 || bus0.grant_id !== 2'd1 || bus0.out_c !== ec(1)) begin
      n_err++; $display("FAIL h0_issue1 valid=%b gid=%0d c=%h exp=1/1/%h", bus0.out_valid, bus0.grant_id, bus0.out_c, ec(1)); end
    bus0.req_valid = 4'b0000;
    tick();
    n_vec++; if (bus0.call_count !== 32'd2 || bus0.busy !== 1'b0) begin n_err++; $display("FAIL h0_count cnt=%0d busy=%b exp=2/0", bus0.call_count, bus0.busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_a !== 16'd0 || bus.grant_id !== 2'd0 || bus.call_count !== 32'd0) begin
      n_err++; $display("FAIL rst_hold busy=%b valid=%b a=%h gid=%0d cnt=%0d exp=0/0/0/0/0", bus.busy, bus.out_valid, bus.out_a, bus.grant_id, bus.call_count); end
    tick();
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_drop got=%b exp=0", bus.out_valid); end

    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    n_vec++; if (bus.call_count !== 32'd1) begin n_err++; $display("FAIL rst_pre_count got=%0d exp=1", bus.call_count); end
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_issue got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.call_count !== 32'd0 || bus.busy !== 1'b0 || bus.out_c !== 32'd0 || bus.grant_id !== 2'd0) begin
      n_err++; $display("FAIL rst_issue valid=%b cnt=%0d busy=%b c=%h gid=%0d exp=0/0/0/0/0", bus.out_valid, bus.call_count, bus.busy, bus.out_c, bus.grant_id); end
    bus.req_valid = 4'b1111;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first got=%b exp=0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_backpressure();
    test_hold0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vpi_call_arbiter.md
Name: vpi_call_arbiter

Overview:
- Shares one VPI parameter-call sink (16-bit a, 7-bit b, 32-bit c, sampled by the $testParams task on posedge clk) between NUM_REQ testbench requesters.
- Grants one requester at a time, round-robin, and latches its parameter triple.
- Holds the triple stable for HOLD_CYCLES, then presents it to the sink with a valid/ready handshake.
- Counts completed calls. Sits between stimulus generators and the VPI-call module.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 2, settle cycles between latching a triple and asserting out_valid (0..255; 0 = no hold state).
- GID_W, 2, width of grant_id; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_a  input  NUM_REQ*16  packed a fields; requester i uses bits [16i+15:16i].
- req_b  input  NUM_REQ*7  packed b fields, same packing.
- req_c  input  NUM_REQ*32  packed c fields, same packing.
- req_ready  output  NUM_REQ  one-hot accept for the granted requester.
- out_a  output  16  latched a to sink.
- out_b  output  7  latched b to sink.
- out_c  output  32  latched c to sink.
- out_valid  output  1  triple is valid for the sink.
- out_ready  input  1  sink accepts the triple.
- grant_id  output  GID_W  index of the current/last granted requester.
- busy  output  1  high in any state other than IDLE.
- call_count  output  32  completed sink handshakes.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - state=IDLE; out_a/out_b/out_c=0; out_valid=0; req_ready=0; busy=0; call_count=0.
  - grant_id=0; internal last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides everything, including mid-transaction: an in-flight triple is dropped, no handshake is completed and no count is added.
- States: IDLE, HOLD, ISSUE.
- IDLE:
  - Combinational round-robin pick g: first i with req_valid[i]=1, scanning from last_grant+1 upward and wrapping modulo NUM_REQ.
  - req_ready = onehot(g) when any req_valid=1, else 0. req_ready is 0 in all other states.
  - Transfer occurs on a posedge with req_valid[g] & req_ready[g]. On transfer, latch out_a/b/c from slice g and set grant_id=g.
  - Next state is HOLD with hold_cnt=HOLD_CYCLES-1, or ISSUE directly if HOLD_CYCLES=0.
  - No requests: stay in IDLE; outputs keep their last values.
- HOLD:
  - out_valid=0; out_a/b/c stable.
  - hold_cnt decrements each cycle; when hold_cnt=0, go to ISSUE next cycle. HOLD lasts exactly HOLD_CYCLES cycles.
- ISSUE:
  - out_valid=1; out_a/b/c and grant_id held stable until handshake.
  - On a posedge with out_ready=1: call_count += 1 (wraps 0xFFFFFFFF -> 0), last_grant=grant_id, next state IDLE.
  - out_ready=0 stalls indefinitely with no change.
- Latency:
  - Request accepted in IDLE -> out_valid high exactly HOLD_CYCLES+1 cycles later.
  - Minimum period per call is HOLD_CYCLES+2 cycles (IDLE, HOLD x N, ISSUE).
- Simultaneous requests: exactly one grant per IDLE visit.
  - Requests not granted keep req_ready=0 and must hold valid and data.
  - A requester deasserting valid before ready gets no transfer; the scan is recomputed every cycle.
- out_ready high outside ISSUE is ignored.
- Slices of non-granted requesters never affect outputs.

Test Plan:
- Single request: HOLD_CYCLES=2, req_valid=4'b0001 with a=16'h1234, b=7'h55, c=32'hDEADBEEF, out_ready=1.
  -> req_ready[0] pulses 1 cycle; out_valid high 3 cycles later for 1 cycle with those values; call_count=1; busy low afterwards.
- Fairness: req_valid=4'b1111 held, out_ready=1.
  -> grants in order 0,1,2,3,0; each grant_id matches its slice data; spacing 4 cycles; call_count=5 after 5 calls.
- Rotation: with last_grant=1, assert req_valid=4'b1001.
  -> requester 3 is granted before 0.
- Backpressure: out_ready=0 for 10 cycles in ISSUE.
  -> out_valid and out_a/b/c stable throughout, call_count unchanged, req_ready=0; out_ready=1 completes the call and count increments once.
- HOLD_CYCLES=0 build: back-to-back requests.
  -> out_valid the cycle after accept; one call per 2 cycles.
- Reset mid-operation: rst pulsed during HOLD, and separately during ISSUE with out_ready=0.
  -> next cycle all outputs 0, state IDLE, call_count=0, no handshake; the following request from requester 0 is granted first.
